ex_seq: RTL
===========

# ex_seq

Execute-stage sequencer that sits directly upstream of the iterative ALU. It accepts one decoded ALU/branch operation per valid/ready handshake and holds the operands stable on the ALU inputs. It pulses the ALU `start` for one cycle, waits for the ALU `done` indication (multi-cycle for pure shifts), and then presents the captured result to writeback through a second valid/ready handshake. It adds no arithmetic of its own beyond result packaging and the writeback-enable decision.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `WSHAM`, `$clog2(WIDTH)`, shift-amount width.
- `WD_LIMIT`, 40, watchdog limit in WAIT cycles; used only when the watchdog is compiled in.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decoded operation available.
- `in_ready` out 1: sequencer accepts an operation this cycle.
- `in_src_a` in WIDTH: operand A.
- `in_src_b` in WIDTH: operand B or immediate.
- `in_f3` in 3: funct3.
- `in_arith` in 1: arithmetic/sub select bit.
- `in_shadd` in 1: shift-and-add op.
- `in_branch` in 1: branch compare op.
- `in_rd` in 5: destination register.
- `alu_start` out 1: one-cycle start pulse to the ALU.
- `alu_src_a`, `alu_src_b` out WIDTH: registered operands.
- `alu_f3` out 3, `alu_arith` out 1, `alu_shadd` out 1, `alu_branch` out 1: registered controls.
- `alu_out` in WIDTH: ALU result.
- `alu_done` in 1: ALU result valid (combinational from the ALU).
- `out_valid` out 1: result available.
- `out_ready` in 1: writeback accepts the result.
- `out_data` out WIDTH: captured ALU result.
- `out_rd` out 5: destination register.
- `out_we` out 1: register write enable.
- `out_taken` out 1: branch taken.
- `wd_err` out 1: watchdog fired (only with `EXSEQ_WATCHDOG_EN`).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `in_ready`=1. On `in_valid`, latch all `in_*` into the operand/control registers and go to ISSUE.
- **ISSUE:** `alu_start`=1 for exactly this cycle, then go to WAIT unconditionally. `alu_done` is ignored in ISSUE.
- **WAIT:** sample `alu_done` each cycle.
  - When `alu_done`=1, capture `alu_out` into `out_data` and go to RESP.
  - While waiting, the operand/control registers stay constant.
- **RESP:** `out_valid`=1 and all outputs are held stable until `out_ready`.
  - `in_ready` = (state==IDLE) || (state==RESP && `out_ready`).
  - If `out_ready` && `in_valid` in RESP, the new operation is latched the same cycle and the FSM goes directly to ISSUE (back-to-back, no IDLE bubble).
  - If `out_ready` && !`in_valid`, go to IDLE.
- **Result packaging:**
  - `out_taken` = latched branch & `alu_out[0]`, captured with `out_data`.
  - `out_we` = !latched branch && (`out_rd` != 0).
  - Branches never write, and `out_data` still carries the compare result.
- `alu_*` operand/control outputs are pure register outputs; `alu_start` is decoded from state==ISSUE.

## Timing
- Reset state: IDLE.
  - Every output is 0 except `in_ready`=1.
  - Reset clears the latched operands/controls, `out_data`, `out_rd`, `out_we`, `out_taken`, and `wd_err` to 0.
- Reset mid-operation: the FSM returns to IDLE on the next edge, the in-flight op is discarded, and `alu_start` is deasserted.
- Non-shift ops: accept at edge N, ISSUE during cycle N+1, WAIT capture at N+2, `out_valid` from cycle N+3. Minimum occupancy is 3 cycles per op.
- Pure shifts by k: WAIT lasts until the ALU reports done; `out_valid` is asserted one cycle after the first WAIT cycle with `alu_done`=1.
- Shift by 0: behaves like a non-shift op.
- `out_valid` never drops without `out_ready`, and `out_data` never changes while `out_valid` && !`out_ready`.
- Stalled writeback keeps the FSM in RESP indefinitely.

## Configuration
- `EXSEQ_WATCHDOG_EN` defined:
  - A cycle counter (width `$clog2(WD_LIMIT+1)`) clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `WD_LIMIT` without `alu_done`, `wd_err` is set sticky (cleared only by `rst`). The FSM then forces RESP with `out_data`=0, `out_we`=0, `out_taken`=0.
- `EXSEQ_WATCHDOG_EN` undefined: no counter; `wd_err` is tied to 0; WAIT is unbounded.

## Test plan
- **ADD:** `in_src_a`=5, `in_src_b`=7, f3=0, `in_rd`=3 → `alu_start` pulses once at N+1; at N+3 `out_valid`=1, `out_data`=12, `out_we`=1, `out_rd`=3.
- **SLL:** `in_src_a`=1, `in_src_b`=31, with an ALU model that deasserts done for 31 cycles → `out_data`=0x8000_0000; `in_ready`=0 throughout; operands stable.
- **BEQ:** a=b=9, `in_branch`=1, `in_rd`=0 → `out_taken`=1, `out_we`=0. Then a BNE with a=9, b=9 → `out_taken`=0.
- **Writeback stall and back-to-back:**
  - `out_ready`=0 for 4 cycles → `out_data` stable throughout.
  - Then `out_ready`=1 with `in_valid`=1 (a=1, b=2, f3=0) → the second op is accepted that cycle, the next cycle is ISSUE, and `out_data`=3 three cycles later.
  - `in_rd`=0 → `out_we`=0.
- **Reset mid-operation:** `rst` during WAIT of a 20-cycle shift → the next cycle is IDLE, `in_ready`=1, `out_valid`=0, no stale result ever appears.
- **Watchdog (`EXSEQ_WATCHDOG_EN`, `WD_LIMIT`=40):** hold `alu_done`=0 → after 40 WAIT cycles `wd_err`=1, `out_valid`=1, `out_we`=0; `wd_err` stays 1 until `rst`.

Source files
------------

// File: rtl/ex_seq.sv
// Execute-stage sequencer: latches one decoded op, pulses the ALU start, waits for done,
// then holds the packaged result for writeback. Define EXSEQ_WATCHDOG_EN to bound the wait.
module ex_seq #(
  parameter int WIDTH    = 32,
  parameter int WSHAM    = $clog2(WIDTH),
  parameter int WD_LIMIT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_src_a,
  input  logic [WIDTH-1:0] in_src_b,
  input  logic [2:0]       in_f3,
  input  logic             in_arith,
  input  logic             in_shadd,
  input  logic             in_branch,
  input  logic [4:0]       in_rd,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [2:0]       alu_f3,
  output logic             alu_arith,
  output logic             alu_shadd,
  output logic             alu_branch,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic             out_taken,
  output logic             wd_err
);

  // state   | meaning
  // S_IDLE  | no op held, ready for a new one
  // S_ISSUE | operands on the ALU inputs, start pulsed
  // S_WAIT  | waiting for alu_done (shifts take several cycles)
  // S_RESP  | result held for writeback until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  if (WSHAM < 1 || WD_LIMIT < 1) begin : g_param_chk
    $error("ex_seq: WSHAM and WD_LIMIT must be at least 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] src_a_q, src_a_d;
  logic [WIDTH-1:0] src_b_q, src_b_d;
  logic [2:0]       f3_q, f3_d;
  logic             arith_q, arith_d;
  logic             shadd_q, shadd_d;
  logic             branch_q, branch_d;
  logic [4:0]       rd_q, rd_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             we_q, we_d;
  logic             taken_q, taken_d;
  logic             wd_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      f3_q     <= '0;
      arith_q  <= 1'b0;
      shadd_q  <= 1'b0;
      branch_q <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      f3_q     <= f3_d;
      arith_q  <= arith_d;
      shadd_q  <= shadd_d;
      branch_q <= branch_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      we_q     <= we_d;
      taken_q  <= taken_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    f3_d      = f3_q;
    arith_d   = arith_q;
    shadd_d   = shadd_q;
    branch_d  = branch_q;
    rd_d      = rd_q;
    data_d    = data_q;
    we_d      = we_q;
    taken_d   = taken_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (alu_done) begin
          data_d  = alu_out;
          taken_d = branch_q & alu_out[0];
          we_d    = !branch_q && (rd_q != 5'd0);
          state_d = S_RESP;
        end else if (wd_fire) begin
          // watchdog expiry: deliver a harmless, non-writing result
          data_d  = '0;
          taken_d = 1'b0;
          we_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (in_valid && in_ready) begin
      src_a_d  = in_src_a;
      src_b_d  = in_src_b;
      f3_d     = in_f3;
      arith_d  = in_arith;
      shadd_d  = in_shadd;
      branch_d = in_branch;
      rd_d     = in_rd;
    end
  end

`ifdef EXSEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q;
    wd_fire  = 1'b0;
    if (state_q == S_ISSUE) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT && !alu_done) begin
      if (wd_cnt_q == WD_W'(WD_LIMIT - 1)) begin
        wd_fire  = 1'b1;
        wd_err_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif

  assign alu_start  = (state_q == S_ISSUE);
  assign alu_src_a  = src_a_q;
  assign alu_src_b  = src_b_q;
  assign alu_f3     = f3_q;
  assign alu_arith  = arith_q;
  assign alu_shadd  = shadd_q;
  assign alu_branch = branch_q;
  assign out_data   = data_q;
  assign out_rd     = rd_q;
  assign out_we     = we_q;
  assign out_taken  = taken_q;

endmodule
